// File: rtl/fetch_sequencer.sv
// Instruction fetch sequencer: issues one fetch at a time, holds the returned
// word for decode, and redirects on branches and flushes. Responses to a
// request that was overtaken by a flush are drained and discarded.
module fetch_sequencer #(
  parameter int                   WORDSIZE    = 32,
  parameter logic [WORDSIZE-1:0]  PC_INIT_VAL = '0
) (
  input  logic                clk,
  input  logic                reset,
  output logic                imem_req,
  output logic [WORDSIZE-1:0] imem_addr,
  input  logic                imem_ack,
  input  logic [WORDSIZE-1:0] imem_rdata,
  output logic                instr_valid,
  output logic [WORDSIZE-1:0] instr,
  output logic [WORDSIZE-1:0] instr_pc,
  input  logic                instr_ready,
  input  logic                pcSrc,
  input  logic [WORDSIZE-1:0] immExt,
  input  logic                flush,
  input  logic [WORDSIZE-1:0] flush_target,
  output logic                misalign_err
);

  typedef enum logic [1:0] {FETCH, DRAIN, VALID, HALT} state_t;

  state_t              state, state_nxt;
  logic [WORDSIZE-1:0] pc, pc_nxt;
  logic [WORDSIZE-1:0] drain_addr;
  logic                run;
  logic                latch, set_err;

  // State register; run holds off the first request until one edge after reset
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= FETCH;
      run   <= 1'b0;
    end else begin
      state <= state_nxt;
      run   <= 1'b1;
    end
  end

  // Next-state and next-pc selection; flush always wins over ack/consume
  always_comb begin
    state_nxt = state;
    pc_nxt    = pc;
    latch     = 1'b0;
    set_err   = 1'b0;
    if (run) begin
      case (state)
        FETCH: begin
          if (flush) begin
            pc_nxt    = flush_target;
            state_nxt = imem_ack ? FETCH : DRAIN;
          end else if (imem_ack) begin
            latch     = 1'b1;
            state_nxt = VALID;
          end
        end
        DRAIN: begin
          if (flush) begin
            pc_nxt    = flush_target;
            state_nxt = DRAIN;
          end else if (imem_ack) begin
            state_nxt = FETCH;
          end
        end
        VALID: begin
          if (flush) begin
            pc_nxt    = flush_target;
            state_nxt = FETCH;
          end else if (instr_ready) begin
            pc_nxt    = pcSrc ? instr_pc + immExt : instr_pc + WORDSIZE'(4);
            state_nxt = FETCH;
          end
        end
        default: state_nxt = HALT;
      endcase
      // Any redirect to a non word-aligned address stops the sequencer
      if (state != HALT && pc_nxt != pc && pc_nxt[1:0] != 2'b00) begin
        set_err   = 1'b1;
        state_nxt = HALT;
      end
    end
  end

  // Datapath registers: pc, held instruction, drained address, sticky error
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc           <= PC_INIT_VAL;
      instr        <= '0;
      instr_pc     <= '0;
      drain_addr   <= '0;
      misalign_err <= 1'b0;
    end else begin
      pc <= pc_nxt;
      if (latch) begin
        instr    <= imem_rdata;
        instr_pc <= pc;
      end
      // The abandoned request keeps its address on the bus while draining
      if (state == FETCH && state_nxt == DRAIN)
        drain_addr <= pc;
      if (set_err)
        misalign_err <= 1'b1;
    end
  end

  // Outputs decoded from state; request and valid are mutually exclusive
  always_comb begin
    imem_req    = run && (state == FETCH || state == DRAIN);
    imem_addr   = (state == DRAIN) ? drain_addr : pc;
    instr_valid = (state == VALID);
  end

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed bench for fetch_sequencer: a scoreboard of expected fetch
// addresses and held words is filled as stimulus is issued and drained as
// the DUT requests/presents them.
module tb_fetch_sequencer;
  localparam int W = 32;

  logic         clk = 1'b0;
  logic         reset;
  logic         imem_req;
  logic [W-1:0] imem_addr;
  logic         imem_ack;
  logic [W-1:0] imem_rdata;
  logic         instr_valid;
  logic [W-1:0] instr;
  logic [W-1:0] instr_pc;
  logic         instr_ready;
  logic         pcSrc;
  logic [W-1:0] immExt;
  logic         flush;
  logic [W-1:0] flush_target;
  logic         misalign_err;

  int n_cmp = 0;
  int n_err = 0;

  logic [W-1:0] exp_addr[$];
  logic [W-1:0] exp_word[$];
  logic [W-1:0] exp_pc[$];

  fetch_sequencer #(.WORDSIZE(W)) dut (
    .clk(clk), .reset(reset),
    .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .instr_valid(instr_valid), .instr(instr), .instr_pc(instr_pc),
    .instr_ready(instr_ready), .pcSrc(pcSrc), .immExt(immExt),
    .flush(flush), .flush_target(flush_target),
    .misalign_err(misalign_err)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Wait for a request, match it against the scoreboard, ack after lat cycles,
  // then check the word is offered to decode.
  task automatic serve(input int lat, input logic [W-1:0] data);
    int n = 0;
    logic [W-1:0] a;
    logic [W-1:0] w;
    logic [W-1:0] p;
    while (!imem_req && n < 20) begin
      tick();
      n++;
    end
    check("req_seen", {31'b0, imem_req}, 32'd1);
    if (!imem_req) return;
    a = exp_addr.pop_front();
    check("req_addr", imem_addr, a);
    for (int k = 1; k < lat; k++) begin
      tick();
      check("req_hold", {31'b0, imem_req}, 32'd1);
      check("addr_hold", imem_addr, a);
    end
    imem_ack = 1'b1;
    imem_rdata = data;
    exp_word.push_back(data);
    exp_pc.push_back(a);
    tick();
    imem_ack = 1'b0;
    imem_rdata = '0;
    w = exp_word.pop_front();
    p = exp_pc.pop_front();
    check("valid", {31'b0, instr_valid}, 32'd1);
    check("instr", instr, w);
    check("instr_pc", instr_pc, p);
    check("req_off_in_valid", {31'b0, imem_req}, 32'd0);
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_req"}, {31'b0, imem_req}, 32'd0);
    check({tag, "_valid"}, {31'b0, instr_valid}, 32'd0);
    check({tag, "_instr"}, instr, 32'd0);
    check({tag, "_ipc"}, instr_pc, 32'd0);
    check({tag, "_err"}, {31'b0, misalign_err}, 32'd0);
  endtask

  initial begin
    reset = 1'b0; imem_ack = 1'b0; imem_rdata = '0; instr_ready = 1'b0;
    pcSrc = 1'b0; immExt = '0; flush = 1'b0; flush_target = '0;
    repeat (2) tick();
    check_reset_vals("rst");

    // first edge after release raises the request at the init address
    reset = 1'b1;
    tick();

    // sequential fetch, ack latency 2, decode always ready
    instr_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      exp_addr.push_back(W'(4 * i));
      serve(2, 32'h1000_0000 | W'(4 * i));
    end
    tick();

    // branch: stall first with pcSrc high, then consume
    instr_ready = 1'b0;
    exp_addr.push_back(32'h10);
    serve(2, 32'h2000_0010);
    pcSrc = 1'b1; immExt = 32'hFFFF_FFF8;
    tick(); tick();
    check("br_stall_valid", {31'b0, instr_valid}, 32'd1);
    check("br_stall_pc", instr_pc, 32'h10);
    check("br_stall_req", {31'b0, imem_req}, 32'd0);
    instr_ready = 1'b1;
    exp_addr.push_back(32'h08);
    tick();
    instr_ready = 1'b0; pcSrc = 1'b0; immExt = '0;
    serve(1, 32'h2000_0008);

    // flush in VALID drops the word; flush while 0x20 is pending drains
    flush = 1'b1; flush_target = 32'h20;
    tick();
    flush = 1'b0;
    check("vflush_drop", {31'b0, instr_valid}, 32'd0);
    check("vflush_addr", imem_addr, 32'h20);
    tick();
    flush = 1'b1; flush_target = 32'h100;
    tick();
    flush = 1'b0;
    check("drain_req", {31'b0, imem_req}, 32'd1);
    check("drain_addr", imem_addr, 32'h20);
    tick(); tick();
    check("drain_addr_hold", imem_addr, 32'h20);
    imem_ack = 1'b1; imem_rdata = 32'hDEAD_0020;
    tick();
    imem_ack = 1'b0; imem_rdata = '0;
    check("drain_discard", {31'b0, instr_valid}, 32'd0);
    exp_addr.push_back(32'h100);
    serve(2, 32'h3000_0100);

    // flush and consume together: flush wins, pcSrc ignored
    flush = 1'b1; flush_target = 32'h200; instr_ready = 1'b1;
    pcSrc = 1'b1; immExt = 32'h40;
    tick();
    flush = 1'b0; pcSrc = 1'b0; immExt = '0;
    check("fvc_valid", {31'b0, instr_valid}, 32'd0);
    exp_addr.push_back(32'h200);
    serve(1, 32'h3000_0200);
    tick();
    check("seq_after_flush", imem_addr, 32'h204);

    // flush with ack in the same FETCH cycle: response discarded
    imem_ack = 1'b1; imem_rdata = 32'hDEAD_0204;
    flush = 1'b1; flush_target = 32'h300;
    tick();
    imem_ack = 1'b0; flush = 1'b0; instr_ready = 1'b0;
    check("fack_valid", {31'b0, instr_valid}, 32'd0);
    check("fack_req", {31'b0, imem_req}, 32'd1);
    exp_addr.push_back(32'h300);
    serve(1, 32'h3000_0300);

    // address wrap on sequential increment
    flush = 1'b1; flush_target = 32'hFFFF_FFFC;
    tick();
    flush = 1'b0;
    exp_addr.push_back(32'hFFFF_FFFC);
    serve(2, 32'h4000_0000);
    instr_ready = 1'b1; pcSrc = 1'b0;
    tick();
    instr_ready = 1'b0;
    check("wrap_req", {31'b0, imem_req}, 32'd1);
    check("wrap_addr", imem_addr, 32'h0);

    // reset while draining abandons the request immediately
    flush = 1'b1; flush_target = 32'h40;
    tick();
    flush = 1'b0;
    check("pre_rst_drain", imem_addr, 32'h0);
    reset = 1'b0;
    #1;
    check_reset_vals("mid_rst");
    tick();
    reset = 1'b1;
    tick();
    check("post_rst_req", {31'b0, imem_req}, 32'd1);
    exp_addr.push_back(32'h0);
    serve(1, 32'h5000_0000);

    // misaligned flush target halts; later flushes and acks are ignored
    flush = 1'b1; flush_target = 32'h102;
    tick();
    flush = 1'b0;
    check("mis_err", {31'b0, misalign_err}, 32'd1);
    check("mis_req", {31'b0, imem_req}, 32'd0);
    check("mis_valid", {31'b0, instr_valid}, 32'd0);
    flush = 1'b1; flush_target = 32'h400; imem_ack = 1'b1;
    repeat (3) tick();
    flush = 1'b0; imem_ack = 1'b0;
    check("halt_req", {31'b0, imem_req}, 32'd0);
    check("halt_valid", {31'b0, instr_valid}, 32'd0);
    check("halt_err", {31'b0, misalign_err}, 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/fetch_sequencer.md
FETCH_SEQUENCER -- requirements
Module: fetch_sequencer

Interface
REQ-001 SHALL have parameter WORDSIZE, default 32, datapath and address width.
REQ-002 SHALL have parameter PC_INIT_VAL, default 32'b0, fetch address after reset.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-low reset (0 = reset asserted).
REQ-005 SHALL have port imem_req  output  1  instruction-memory fetch request.
REQ-006 SHALL have port imem_addr  output  WORDSIZE  fetch address.
REQ-007 SHALL have port imem_ack  input  1  memory response valid; imem_rdata is valid in the same cycle.
REQ-008 SHALL have port imem_rdata  input  WORDSIZE  fetched instruction word.
REQ-009 SHALL have port instr_valid  output  1  instruction offered to decode.
REQ-010 SHALL have port instr  output  WORDSIZE  held instruction word.
REQ-011 SHALL have port instr_pc  output  WORDSIZE  address of the held instruction.
REQ-012 SHALL have port instr_ready  input  1  decode consumes the instruction this cycle.
REQ-013 SHALL have port pcSrc  input  1  taken branch (branch AND zero); sampled only on consume.
REQ-014 SHALL have port immExt  input  WORDSIZE  branch offset from the immediate generator.
REQ-015 SHALL have port flush  input  1  asynchronous-to-flow redirect request (jump/trap), any cycle.
REQ-016 SHALL have port flush_target  input  WORDSIZE  absolute redirect address.
REQ-017 SHALL have port misalign_err  output  1  sticky target-misalignment flag.

Function
REQ-018 SHALL implement states FETCH, DRAIN, VALID and HALT in a registered state machine.
REQ-019 In FETCH, the block SHALL drive imem_req=1 and imem_addr=pc, and hold both stable until imem_ack.
REQ-020 In FETCH with imem_ack=1 and flush=0, the block SHALL latch imem_rdata into instr and pc into instr_pc, then go to VALID; an ack in the first request cycle counts (minimum latency 1 cycle).
REQ-021 In VALID, the block SHALL drive instr_valid=1 and imem_req=0, with instr and instr_pc held stable until consumed.
REQ-022 In VALID with instr_ready=1, the next pc SHALL be pcSrc ? instr_pc+immExt : instr_pc+4, computed modulo 2^WORDSIZE (wrap, no overflow flag), and the block SHALL go to FETCH.
REQ-023 In VALID, pcSrc and immExt SHALL be ignored whenever instr_ready=0.
REQ-024 On flush=1 in VALID, the block SHALL set pc=flush_target, drop the held instruction (instr_valid=0 next cycle), and go to FETCH; flush SHALL take priority over instr_ready.
REQ-025 On flush=1 in FETCH with imem_ack=1, the block SHALL discard the response, set pc=flush_target, and remain in FETCH.
REQ-026 On flush=1 in FETCH with imem_ack=0, the block SHALL set pc=flush_target and go to DRAIN; imem_addr SHALL keep the old address until ack.
REQ-027 In DRAIN, the block SHALL keep imem_req=1, and on imem_ack SHALL discard the data and go to FETCH; a further flush in DRAIN SHALL overwrite pc and stay in DRAIN.
REQ-028 Whenever a new pc (branch or flush) has bits [1:0] != 0, the block SHALL set misalign_err=1 and go to HALT.
REQ-029 In HALT, the block SHALL hold imem_req=0 and instr_valid=0 until reset; flush SHALL be ignored in HALT.
REQ-030 The block SHALL never hold imem_req=1 and instr_valid=1 in the same cycle.

Reset
REQ-031 While reset=0, the block SHALL hold state=FETCH, pc=PC_INIT_VAL, instr=0, instr_pc=0, instr_valid=0, misalign_err=0, and imem_req=0.
REQ-032 On the first rising edge after reset goes to 1, the block SHALL assert imem_req with imem_addr=PC_INIT_VAL; reset asserted mid-transaction SHALL abandon any outstanding request without a drain.

Verification
REQ-033 Sequential fetch: the bench SHALL apply reset, ack each request after 2 cycles, and hold instr_ready=1; required response is imem_addr 0x0, 0x4, 0x8 and instr_pc matching each fetched word.
REQ-034 Branch: the bench SHALL consume instr_pc=0x10 with pcSrc=1 and immExt=0xFFFFFFF8; required response is the next imem_addr=0x08, and pcSrc=1 with instr_ready=0 SHALL change nothing.
REQ-035 Flush during wait: the bench SHALL assert flush with target 0x100 while a fetch of 0x20 is pending, then ack 3 cycles later; required response is DRAIN, the 0x20 data discarded, and the next request at 0x100.
REQ-036 Flush versus consume: the bench SHALL apply flush=1 and instr_ready=1 in the same VALID cycle with target 0x200; required response is the next fetch at 0x200, ignoring pcSrc.
REQ-037 Misalignment and wrap: the bench SHALL apply a flush target of 0x102; required response is misalign_err=1 and HALT with no further imem_req. Separately, instr_pc=0xFFFFFFFC with pcSrc=0 SHALL produce a next fetch at 0x0.
REQ-038 Reset mid-operation: the bench SHALL assert reset=0 during DRAIN; required response is all outputs at reset values immediately, then a fetch at PC_INIT_VAL after release.
